// File: rtl/hbm_send_back_mc_if.sv
// DMA write-side bundle for hbm_send_back_mc: command stream and data stream.
// The engine drives through master; the host DMA side uses slave.
interface hbm_send_back_mc_if #(
    parameter int DATA_W = 512
);
    localparam int BYTES = DATA_W / 8;

    logic              m_axis_dma_write_cmd_valid;
    logic              m_axis_dma_write_cmd_ready;
    logic [63:0]       m_axis_dma_write_cmd_address;
    logic [31:0]       m_axis_dma_write_cmd_length;
    logic              m_axis_dma_write_data_valid;
    logic              m_axis_dma_write_data_ready;
    logic [DATA_W-1:0] m_axis_dma_write_data_data;
    logic [BYTES-1:0]  m_axis_dma_write_data_keep;
    logic              m_axis_dma_write_data_last;

    modport master (
        output m_axis_dma_write_cmd_valid,
        output m_axis_dma_write_cmd_address,
        output m_axis_dma_write_cmd_length,
        input  m_axis_dma_write_cmd_ready,
        output m_axis_dma_write_data_valid,
        output m_axis_dma_write_data_data,
        output m_axis_dma_write_data_keep,
        output m_axis_dma_write_data_last,
        input  m_axis_dma_write_data_ready
    );

    modport slave (
        input  m_axis_dma_write_cmd_valid,
        input  m_axis_dma_write_cmd_address,
        input  m_axis_dma_write_cmd_length,
        output m_axis_dma_write_cmd_ready,
        input  m_axis_dma_write_data_valid,
        input  m_axis_dma_write_data_data,
        input  m_axis_dma_write_data_keep,
        input  m_axis_dma_write_data_last,
        output m_axis_dma_write_data_ready
    );
endinterface

// File: rtl/hbm_send_back_mc.sv
// Multi-channel HBM write-back engine: per-channel FIFOs, boundary-safe
// bursts, round-robin arbitration onto one DMA command/data stream.
module hbm_send_back_mc #(
    parameter int NUM_CH          = 4,
    parameter int DATA_W          = 512,
    parameter int FIFO_DEPTH      = 512,
    parameter int MAX_BURST_BYTES = 4096,
    parameter int AF_MARGIN       = 16
) (
    input  logic                     hbm_clk,
    input  logic                     hbm_aresetn,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH*64-1:0]     addr_x,
    input  logic [NUM_CH*32-1:0]     data_length,
    input  logic [NUM_CH*DATA_W-1:0] back_data,
    input  logic [NUM_CH-1:0]        back_valid,
    output logic [NUM_CH-1:0]        almost_full,
    output logic [NUM_CH-1:0]        overflow,
    output logic [NUM_CH-1:0]        done,
    output logic [NUM_CH-1:0]        busy,
    hbm_send_back_mc_if.master       dma
);
    localparam int BYTES = DATA_W / 8;
    localparam int BW    = $clog2(BYTES);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int MBW   = $clog2(MAX_BURST_BYTES);
    localparam int BTW   = $clog2(MAX_BURST_BYTES / BYTES) + 1;
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AF_TH = FIFO_DEPTH - AF_MARGIN;

    typedef enum logic [1:0] {IDLE, ARB, SEND_CMD, SEND_DATA} state_t;

    logic [DATA_W-1:0] mem_q [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0] bd_q [NUM_CH];
    logic [NUM_CH-1:0] bv_q;
    logic [AW-1:0]     wr_ptr_q [NUM_CH];
    logic [AW-1:0]     wr_ptr_d [NUM_CH];
    logic [AW-1:0]     rd_ptr_q [NUM_CH];
    logic [AW-1:0]     rd_ptr_d [NUM_CH];
    logic [CW-1:0]     cnt_q [NUM_CH];
    logic [CW-1:0]     cnt_d [NUM_CH];
    logic [NUM_CH-1:0] wr_en, rd_en;
    logic [NUM_CH-1:0] af_q, af_d, ovf_q, ovf_d;

    logic [NUM_CH-1:0] busy_q, busy_d, done_q, done_d;
    logic [NUM_CH-1:0] zp_q, zp_d, ok_q, ok_d, elig;
    logic [63:0]       addr_q [NUM_CH];
    logic [63:0]       addr_d [NUM_CH];
    logic [31:0]       rem_q [NUM_CH];
    logic [31:0]       rem_d [NUM_CH];
    logic [31:0]       cb_q [NUM_CH];
    logic [31:0]       cb_d [NUM_CH];
    logic [BTW-1:0]    cn_q [NUM_CH];
    logic [BTW-1:0]    cn_d [NUM_CH];

    state_t         state_q;
    logic [CHW-1:0] grant_q, rr_q, gnt_idx;
    logic           gnt_found;
    logic           cmd_valid_q;
    logic [63:0]    cmd_addr_q;
    logic [31:0]    cmd_len_q;
    logic [BTW-1:0] beat_q, last_beat_q;
    logic           in_data, dat_valid, dat_hs;
    logic           is_last, job_end, burst_fin;
    logic [BW-1:0]  tail;

    assign in_data   = (state_q == SEND_DATA);
    assign dat_valid = in_data && (cnt_q[grant_q] != '0);
    assign dat_hs    = dat_valid && dma.m_axis_dma_write_data_ready;
    assign is_last   = (beat_q == last_beat_q);
    assign burst_fin = dat_hs && is_last;
    assign job_end   = is_last && (rem_q[grant_q] == cb_q[grant_q]);
    assign tail      = rem_q[grant_q][BW-1:0];

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_en[c]    = bv_q[c] && (cnt_q[c] != CW'(FIFO_DEPTH));
            rd_en[c]    = dat_hs && (grant_q == CHW'(c));
            wr_ptr_d[c] = wr_ptr_q[c] + AW'(wr_en[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + AW'(rd_en[c]);
            cnt_d[c]    = cnt_q[c] + CW'(wr_en[c]) - CW'(rd_en[c]);
            ovf_d[c]    = ovf_q[c] | (bv_q[c] & ~wr_en[c]);
            af_d[c]     = (cnt_d[c] >= CW'(AF_TH));
        end
    end

    always_comb begin : job_c
        logic [63:0] ax;
        logic [31:0] ln;
        logic [31:0] space;
        logic        st_ok;
        logic        chg;
        ax    = '0;
        ln    = '0;
        space = '0;
        st_ok = 1'b0;
        chg   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            ax        = addr_x[c*64 +: 64];
            ln        = data_length[c*32 +: 32];
            st_ok     = start[c] && !busy_q[c];
            chg       = 1'b0;
            busy_d[c] = busy_q[c];
            addr_d[c] = addr_q[c];
            rem_d[c]  = rem_q[c];
            zp_d[c]   = st_ok && (ln == '0);
            done_d[c] = zp_q[c];
            if (st_ok && (ln != '0)) begin
                busy_d[c] = 1'b1;
                addr_d[c] = ax & ~64'(BYTES - 1);
                rem_d[c]  = ln;
                chg       = 1'b1;
            end
            if (burst_fin && (grant_q == CHW'(c))) begin
                addr_d[c] = addr_q[c] + {32'd0, cb_q[c]};
                rem_d[c]  = rem_q[c] - cb_q[c];
                chg       = 1'b1;
                if (rem_q[c] == cb_q[c]) begin
                    busy_d[c] = 1'b0;
                    done_d[c] = 1'b1;
                end
            end
            // Chunk registers lag the job registers by one cycle; ok_q
            // marks when they describe the current address/remaining.
            space = 32'(MAX_BURST_BYTES)
                  - {{(32-MBW){1'b0}}, addr_q[c][MBW-1:0]};
            cb_d[c] = (rem_q[c] < space) ? rem_q[c] : space;
            cn_d[c] = BTW'((cb_d[c] + 32'(BYTES - 1)) >> BW);
            ok_d[c] = busy_q[c] && !chg;
            elig[c] = busy_q[c] && ok_q[c]
                   && (32'(cnt_q[c]) >= 32'(cn_q[c]));
        end
    end

    always_comb begin : arb_c
        int k;
        k         = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            k = int'(rr_q) + i;
            if (k >= NUM_CH) k = k - NUM_CH;
            if (!gnt_found && elig[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = CHW'(k);
            end
        end
    end

    always_ff @(posedge hbm_clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            bd_q[c] <= back_data[c*DATA_W +: DATA_W];
            if (wr_en[c]) mem_q[c][wr_ptr_q[c]] <= bd_q[c];
        end
    end

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            bv_q   <= '0;
            af_q   <= '0;
            ovf_q  <= '0;
            busy_q <= '0;
            done_q <= '0;
            zp_q   <= '0;
            ok_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
                addr_q[c]   <= '0;
                rem_q[c]    <= '0;
                cb_q[c]     <= '0;
                cn_q[c]     <= '0;
            end
        end else begin
            bv_q   <= back_valid;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
            zp_q   <= zp_d;
            ok_q   <= ok_d;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
                addr_q[c]   <= addr_d[c];
                rem_q[c]    <= rem_d[c];
                cb_q[c]     <= cb_d[c];
                cn_q[c]     <= cn_d[c];
            end
        end
    end

    always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
        if (!hbm_aresetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|elig) state_q <= ARB;
                end
                ARB: begin
                    if (gnt_found) begin
                        grant_q     <= gnt_idx;
                        rr_q        <= (gnt_idx == CHW'(NUM_CH - 1))
                                     ? '0 : gnt_idx + CHW'(1);
                        cmd_addr_q  <= addr_q[gnt_idx];
                        cmd_len_q   <= cb_q[gnt_idx];
                        last_beat_q <= cn_q[gnt_idx] - BTW'(1);
                        beat_q      <= '0;
                        cmd_valid_q <= 1'b1;
                        state_q     <= SEND_CMD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SEND_CMD: begin
                    if (dma.m_axis_dma_write_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        state_q     <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (dat_hs) begin
                        beat_q <= beat_q + BTW'(1);
                        if (is_last) state_q <= (|elig) ? ARB : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dma.m_axis_dma_write_cmd_valid   = cmd_valid_q;
    assign dma.m_axis_dma_write_cmd_address = cmd_addr_q;
    assign dma.m_axis_dma_write_cmd_length  = cmd_len_q;
    assign dma.m_axis_dma_write_data_valid  = dat_valid;
    assign dma.m_axis_dma_write_data_last   = in_data && is_last;
    assign dma.m_axis_dma_write_data_data   =
        in_data ? mem_q[grant_q][rd_ptr_q[grant_q]] : '0;
    assign dma.m_axis_dma_write_data_keep   =
        !in_data ? '0 :
        (job_end && (tail != '0)) ? ~({BYTES{1'b1}} << tail) : '1;

    assign almost_full = af_q;
    assign overflow    = ovf_q;
    assign done        = done_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_hbm_send_back_mc.sv
// Scoreboard bench for hbm_send_back_mc: directed jobs push expected
// commands/beats; a negedge monitor pops and compares DMA traffic.
module tb_hbm_send_back_mc;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 512;
    localparam int BYTES  = DATA_W / 8;

    logic                     hbm_clk = 1'b0;
    logic                     hbm_aresetn = 1'b0;
    logic [NUM_CH-1:0]        start = '0;
    logic [NUM_CH*64-1:0]     addr_x = '0;
    logic [NUM_CH*32-1:0]     data_length = '0;
    logic [NUM_CH*DATA_W-1:0] back_data = '0;
    logic [NUM_CH-1:0]        back_valid = '0;
    logic [NUM_CH-1:0]        almost_full, overflow, done, busy;

    hbm_send_back_mc_if #(.DATA_W(DATA_W)) dma ();

    hbm_send_back_mc #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(512),
        .MAX_BURST_BYTES(4096), .AF_MARGIN(16)
    ) u_dut (
        .hbm_clk(hbm_clk), .hbm_aresetn(hbm_aresetn),
        .start(start), .addr_x(addr_x), .data_length(data_length),
        .back_data(back_data), .back_valid(back_valid),
        .almost_full(almost_full), .overflow(overflow),
        .done(done), .busy(busy), .dma(dma)
    );

    always #5 hbm_clk = ~hbm_clk;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
    } cmd_t;
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [BYTES-1:0]  keep;
        logic              last;
    } beat_t;

    cmd_t  exp_cmd [$];
    beat_t exp_beat [$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    exp_done [NUM_CH];
    int    got_done [NUM_CH];
    logic  tog = 1'b0;

    function automatic logic [DATA_W-1:0] mkdat(int ch, int idx);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int w = 0; w < DATA_W / 32; w++)
            d[w*32 +: 32] = {8'(ch), 8'(w), 16'(idx)};
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hbm_clk);
        #1;
    endtask

    task automatic push_burst(input logic [63:0] a, input int len,
                              input int ch, input int idx0,
                              input logic [BYTES-1:0] last_keep);
        cmd_t  c;
        beat_t b;
        int    nb;
        nb = (len + BYTES - 1) / BYTES;
        c.addr = a;
        c.len  = 32'(len);
        exp_cmd.push_back(c);
        for (int i = 0; i < nb; i++) begin
            b.data = mkdat(ch, idx0 + i);
            b.last = (i == nb - 1);
            b.keep = (i == nb - 1) ? last_keep : '1;
            exp_beat.push_back(b);
        end
    endtask

    task automatic fill(input logic [NUM_CH-1:0] mask, input int n,
                        input int idx0);
        for (int i = 0; i < n; i++) begin
            tick();
            back_valid = mask;
            for (int c = 0; c < NUM_CH; c++)
                back_data[c*DATA_W +: DATA_W] = mkdat(c, idx0 + i);
        end
        tick();
        back_valid = '0;
    endtask

    task automatic set_job(input int ch, input logic [63:0] a,
                           input logic [31:0] len);
        addr_x[ch*64 +: 64]      = a;
        data_length[ch*32 +: 32] = len;
        start[ch]                = 1'b1;
    endtask

    task automatic do_start(input int ch, input logic [63:0] a,
                            input logic [31:0] len);
        tick();
        set_job(ch, a, len);
        tick();
        start = '0;
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int t;
        t = 0;
        while ((exp_cmd.size() != 0 || exp_beat.size() != 0) && t < budget) begin
            @(posedge hbm_clk);
            t++;
        end
        n_checks++;
        if (exp_cmd.size() != 0 || exp_beat.size() != 0) begin
            n_errors++;
            $display("FAIL %s_timeout: %0d cmds %0d beats pending, required 0",
                     nm, exp_cmd.size(), exp_beat.size());
        end
        repeat (6) tick();
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("%s_done_cnt_ch%0d", nm, c),
                64'(got_done[c]), 64'(exp_done[c]));
        chk({nm, "_busy"}, 64'(busy), 64'd0);
    endtask

    cmd_t              mc;
    beat_t             mb;
    logic              stall_q = 1'b0;
    logic [DATA_W-1:0] st_data;
    logic [BYTES-1:0]  st_keep;
    logic              st_last;

    always @(negedge hbm_clk) begin
        if (hbm_aresetn) begin
            if (dma.m_axis_dma_write_cmd_valid && dma.m_axis_dma_write_cmd_ready) begin
                if (exp_cmd.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL cmd_unexpected: got addr %0h len %0h, required none",
                             dma.m_axis_dma_write_cmd_address,
                             dma.m_axis_dma_write_cmd_length);
                end else begin
                    mc = exp_cmd.pop_front();
                    chk("cmd_addr", dma.m_axis_dma_write_cmd_address, mc.addr);
                    chk("cmd_len", 64'(dma.m_axis_dma_write_cmd_length), 64'(mc.len));
                end
            end
            if (stall_q) begin
                n_checks++;
                if (!dma.m_axis_dma_write_data_valid ||
                    dma.m_axis_dma_write_data_data !== st_data ||
                    dma.m_axis_dma_write_data_keep !== st_keep ||
                    dma.m_axis_dma_write_data_last !== st_last) begin
                    n_errors++;
                    $display("FAIL stall_hold: got v%0b k%0h l%0b, required v1 k%0h l%0b",
                             dma.m_axis_dma_write_data_valid,
                             dma.m_axis_dma_write_data_keep,
                             dma.m_axis_dma_write_data_last, st_keep, st_last);
                end
            end
            stall_q = dma.m_axis_dma_write_data_valid && !dma.m_axis_dma_write_data_ready;
            st_data = dma.m_axis_dma_write_data_data;
            st_keep = dma.m_axis_dma_write_data_keep;
            st_last = dma.m_axis_dma_write_data_last;
            if (dma.m_axis_dma_write_data_valid && dma.m_axis_dma_write_data_ready) begin
                if (exp_beat.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL beat_unexpected: got data %0h, required none",
                             dma.m_axis_dma_write_data_data[31:0]);
                end else begin
                    mb = exp_beat.pop_front();
                    n_checks++;
                    if (dma.m_axis_dma_write_data_data !== mb.data) begin
                        n_errors++;
                        $display("FAIL beat_data: got %h required %h",
                                 dma.m_axis_dma_write_data_data, mb.data);
                    end
                    chk("beat_keep", 64'(dma.m_axis_dma_write_data_keep), 64'(mb.keep));
                    chk("beat_last", 64'(dma.m_axis_dma_write_data_last), 64'(mb.last));
                end
            end
            for (int c = 0; c < NUM_CH; c++)
                if (done[c]) got_done[c]++;
        end
    end

    initial begin
        dma.m_axis_dma_write_cmd_ready  = 1'b1;
        dma.m_axis_dma_write_data_ready = 1'b1;
        forever begin
            @(posedge hbm_clk);
            #1;
            if (tog) begin
                dma.m_axis_dma_write_data_ready = ~dma.m_axis_dma_write_data_ready;
                dma.m_axis_dma_write_cmd_ready  = dma.m_axis_dma_write_data_ready;
            end else begin
                dma.m_axis_dma_write_data_ready = 1'b1;
                dma.m_axis_dma_write_cmd_ready  = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            exp_done[c] = 0;
            got_done[c] = 0;
        end
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cmd_valid", 64'(dma.m_axis_dma_write_cmd_valid), 64'd0);
        hbm_aresetn = 1'b1;
        repeat (2) tick();
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data_valid", 64'(dma.m_axis_dma_write_data_valid), 64'd0);
        chk("rst_data_keep", 64'(dma.m_axis_dma_write_data_keep), 64'd0);
        chk("rst_data_last", 64'(dma.m_axis_dma_write_data_last), 64'd0);

        // single aligned burst
        fill(4'b0001, 4, 0);
        push_burst(64'h1000, 256, 0, 0, '1);
        exp_done[0]++;
        do_start(0, 64'h1000, 32'd256);
        chk("t1_busy", 64'(busy[0]), 64'd1);
        wait_drain(500, "t1");

        // split at the 4 KiB boundary
        fill(4'b0001, 4, 0);
        push_burst(64'h0F80, 128, 0, 0, '1);
        push_burst(64'h1000, 128, 0, 2, '1);
        exp_done[0]++;
        do_start(0, 64'h0F80, 32'h100);
        wait_drain(500, "t2");

        // partial final beat: 100 bytes -> 36 bytes on beat 1
        fill(4'b0010, 2, 0);
        push_burst(64'h2000, 100, 1, 0, 64'h0000000FFFFFFFFF);
        exp_done[1]++;
        do_start(1, 64'h2000, 32'd100);
        wait_drain(500, "t3");

        // fill ch3 past its depth with no job
        fill(4'b1000, 495, 0);
        repeat (3) tick();
        chk("t5_af_495", 64'(almost_full[3]), 64'd0);
        fill(4'b1000, 1, 495);
        repeat (3) tick();
        chk("t5_af_496", 64'(almost_full[3]), 64'd1);
        fill(4'b1000, 16, 496);
        repeat (3) tick();
        chk("t5_ovf_512", 64'(overflow[3]), 64'd0);
        fill(4'b1000, 1, 512);
        repeat (3) tick();
        chk("t5_ovf_513", 64'(overflow[3]), 64'd1);
        chk("t5_ovf_others", 64'(overflow[2:0]), 64'd0);
        for (int k = 0; k < 8; k++)
            push_burst(64'h40000 + 64'(k) * 64'h1000, 4096, 3, k * 64, '1);
        exp_done[3]++;
        do_start(3, 64'h40000, 32'd32768);
        wait_drain(5000, "t5");
        chk("t5_af_drained", 64'(almost_full[3]), 64'd0);
        chk("t5_ovf_sticky", 64'(overflow[3]), 64'd1);

        // two channels interleave round-robin
        fill(4'b0101, 128, 0);
        push_burst(64'h10000, 4096, 0, 0, '1);
        push_burst(64'h20000, 4096, 2, 0, '1);
        push_burst(64'h11000, 4096, 0, 64, '1);
        push_burst(64'h21000, 4096, 2, 64, '1);
        exp_done[0]++;
        exp_done[2]++;
        tick();
        set_job(0, 64'h10000, 32'd8192);
        set_job(2, 64'h20000, 32'd8192);
        tick();
        start = '0;
        repeat (3) tick();
        chk("t4_busy", 64'(busy), 64'b0101);
        do_start(0, 64'h90000, 32'd64);
        wait_drain(3000, "t4");

        // stalling ready plus a zero-length job on ch1
        fill(4'b0001, 8, 0);
        push_burst(64'h3000, 512, 0, 0, '1);
        exp_done[0]++;
        exp_done[1]++;
        tog = 1'b1;
        do_start(0, 64'h3000, 32'd512);
        repeat (4) tick();
        do_start(1, 64'h5000, 32'd0);
        wait_drain(1000, "t6");
        tog = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
